// File: rtl/mask_majority_filter.sv
// rtl/mask_majority_filter.sv - streaming 3x3 majority filter for the 1-bit colour-match mask
module mask_majority_filter #(
  parameter int IMG_W  = 618,
  parameter int IMG_H  = 478,
  parameter int THRESH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [12:0] i_row,
  input  logic [12:0] i_col,
  input  logic        i_color,
  output logic        o_valid,
  output logic [12:0] o_row,
  output logic [12:0] o_col,
  output logic [3:0]  o_count,
  output logic        o_color
);

  localparam int          AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [12:0] W_C    = 13'(IMG_W);
  localparam logic [12:0] H_C    = 13'(IMG_H);
  localparam logic [12:0] HM1_C  = 13'(IMG_H - 1);
  localparam logic [3:0]  TH_C   = 4'(THRESH);

  logic          accept;
  logic [AW-1:0] idx;
  logic          lb_a_rd, lb_b_rd;
  logic          lb_a_q [IMG_W];
  logic          lb_b_q [IMG_W];

  // Window columns, oldest first; each column is {row r-2, row r-1, row r}.
  logic [2:0]  col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic        sync_q, sync_d;
  logic        p_valid_q, p_valid_d;
  logic [12:0] p_row_q, p_row_d, p_col_q, p_col_d;
  logic        p_border_q, p_border_d;

  logic        o_valid_q, o_valid_d;
  logic [12:0] o_row_q, o_row_d, o_col_q, o_col_d;
  logic [3:0]  o_count_q, o_count_d;
  logic        o_color_q, o_color_d;
  logic [8:0]  win;
  logic [3:0]  cnt;

  always_comb begin
    accept  = i_valid && (i_row < H_C) && (i_col < W_C);
    idx     = i_col[AW-1:0];
    lb_a_rd = lb_a_q[idx];
    lb_b_rd = lb_b_q[idx];

    col0_d     = col0_q;
    col1_d     = col1_q;
    col2_d     = col2_q;
    sync_d     = sync_q;
    p_row_d    = p_row_q;
    p_col_d    = p_col_q;
    p_border_d = p_border_q;

    if (accept) begin
      if (i_col == 13'd0) begin
        col0_d = 3'b000;
        col1_d = 3'b000;
      end else begin
        col0_d = col1_q;
        col1_d = col2_q;
      end
      col2_d = {lb_b_rd, lb_a_rd, i_color};
      if (i_row == 13'd0 && i_col == 13'd0) begin
        sync_d = 1'b1;
      end
    end

    p_valid_d = accept && sync_d && (i_row != 13'd0) && (i_col != 13'd0);
    if (p_valid_d) begin
      p_row_d    = i_row - 13'd1;
      p_col_d    = i_col - 13'd1;
      p_border_d = (p_row_d == 13'd0) || (p_col_d == 13'd0) || (p_row_d == HM1_C);
    end
  end

  always_comb begin
    win = {col0_q, col1_q, col2_q};
    cnt = 4'd0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + {3'b000, win[i]};
    end

    o_valid_d = p_valid_q;
    o_row_d   = o_row_q;
    o_col_d   = o_col_q;
    o_count_d = o_count_q;
    o_color_d = o_color_q;
    if (p_valid_q) begin
      o_row_d   = p_row_q;
      o_col_d   = p_col_q;
      // Border centres see stale line-buffer rows, so they are forced to zero.
      o_count_d = p_border_q ? 4'd0 : cnt;
      o_color_d = !p_border_q && (cnt >= TH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b_q[idx] <= lb_a_rd;
      lb_a_q[idx] <= i_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col0_q     <= 3'b000;
      col1_q     <= 3'b000;
      col2_q     <= 3'b000;
      sync_q     <= 1'b0;
      p_valid_q  <= 1'b0;
      p_row_q    <= 13'd0;
      p_col_q    <= 13'd0;
      p_border_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_row_q    <= 13'd0;
      o_col_q    <= 13'd0;
      o_count_q  <= 4'd0;
      o_color_q  <= 1'b0;
    end else begin
      col0_q     <= col0_d;
      col1_q     <= col1_d;
      col2_q     <= col2_d;
      sync_q     <= sync_d;
      p_valid_q  <= p_valid_d;
      p_row_q    <= p_row_d;
      p_col_q    <= p_col_d;
      p_border_q <= p_border_d;
      o_valid_q  <= o_valid_d;
      o_row_q    <= o_row_d;
      o_col_q    <= o_col_d;
      o_count_q  <= o_count_d;
      o_color_q  <= o_color_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_row   = o_row_q;
  assign o_col   = o_col_q;
  assign o_count = o_count_q;
  assign o_color = o_color_q;

endmodule

// File: tb/tb_mask_majority_filter.sv
// tb/tb_mask_majority_filter.sv - directed bench for mask_majority_filter on an 8x6 image
module tb_mask_majority_filter;
  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [12:0] i_row, i_col;
  logic        i_color;
  logic        o_valid_a, o_color_a, o_valid_b, o_color_b;
  logic [12:0] o_row_a, o_col_a, o_row_b, o_col_b;
  logic [3:0]  o_count_a, o_count_b;

  int checks = 0;
  int failures = 0;

  logic img [0:H-1][0:W-1];
  int   q_row[$], q_col[$], q_cnt[$];
  bit   q_c5[$], q_c9[$], q_v9[$];

  always #5 clk = ~clk;

  mask_majority_filter #(.IMG_W(W), .IMG_H(H), .THRESH(5)) u_t5 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_row(i_row), .i_col(i_col), .i_color(i_color),
    .o_valid(o_valid_a), .o_row(o_row_a), .o_col(o_col_a), .o_count(o_count_a), .o_color(o_color_a)
  );

  mask_majority_filter #(.IMG_W(W), .IMG_H(H), .THRESH(9)) u_t9 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_row(i_row), .i_col(i_col), .i_color(i_color),
    .o_valid(o_valid_b), .o_row(o_row_b), .o_col(o_col_b), .o_count(o_count_b), .o_color(o_color_b)
  );

  always @(negedge clk) begin
    if (o_valid_a) begin
      q_row.push_back(int'(o_row_a));
      q_col.push_back(int'(o_col_a));
      q_cnt.push_back(int'(o_count_a));
      q_c5.push_back(o_color_a);
      q_c9.push_back(o_color_b);
      q_v9.push_back(o_valid_b);
    end
  end

  task automatic pixel(input bit v, input int r, input int c, input bit col);
    @(negedge clk);
    i_valid = v;
    i_row   = 13'(r);
    i_col   = 13'(c);
    i_color = col;
  endtask

  task automatic idle(input int n);
    repeat (n) pixel(1'b0, 0, 0, 1'b0);
  endtask

  task automatic clear_q();
    q_row.delete(); q_col.delete(); q_cnt.delete();
    q_c5.delete(); q_c9.delete(); q_v9.delete();
  endtask

  task automatic fill(input bit v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic drive_frame(input bit gaps, input bit oor, input int tail);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) pixel(1'b0, r, c, 1'b1);
        if (oor && $urandom_range(0, 2) == 0) begin
          pixel(1'b1, r, W, 1'b1);
          pixel(1'b1, H, c, 1'b1);
        end
        pixel(1'b1, r, c, img[r][c]);
      end
    end
    idle(tail);
  endtask

  function automatic int exp_cnt(input int cr, input int cc);
    int s = 0;
    if (cr == 0 || cc == 0 || cr == H - 1) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += int'(img[cr+dr][cc+dc]);
    return s;
  endfunction

  task automatic check_frame(input string name);
    int n;
    checks++;
    if (q_row.size() !== 35) begin
      failures++;
      $display("FAIL %s output_count actual=%0d required=35", name, q_row.size());
    end
    n = (q_row.size() < 35) ? q_row.size() : 35;
    for (int k = 0; k < n; k++) begin
      int er, ec, en;
      bit e5, e9;
      er = k / 7; ec = k % 7 + 0; en = exp_cnt(er, ec);
      e5 = (en >= 5); e9 = (en >= 9);
      checks++;
      if (q_row[k] !== er || q_col[k] !== ec || q_cnt[k] !== en || q_c5[k] !== e5 ||
          q_c9[k] !== e9 || q_v9[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s out%0d actual=(%0d,%0d) cnt=%0d c5=%0d c9=%0d v9=%0d required=(%0d,%0d) cnt=%0d c5=%0d c9=%0d v9=1",
                 name, k, q_row[k], q_col[k], q_cnt[k], q_c5[k], q_c9[k], q_v9[k], er, ec, en, e5, e9);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_row = '0; i_col = '0; i_color = 1'b0;
    #23;
    checks++;
    if ({o_valid_a, o_row_a, o_col_a, o_count_a, o_color_a} !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%0d/%0d/%0d/%0d/%0d required=0/0/0/0/0",
               o_valid_a, o_row_a, o_col_a, o_count_a, o_color_a);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    clear_q(); fill(1'b1);
    drive_frame(1'b0, 1'b0, 3);
    check_frame("all_ones");
    checks++;
    if (q_cnt.size() < 35 || q_cnt[8] !== 9 || q_c5[8] !== 1'b1 || q_cnt[1] !== 0) begin
      failures++;
      $display("FAIL all_ones_hand actual=%0d required=centre(1,1)=9 centre(0,1)=0", q_cnt.size());
    end
    checks++;
    if (o_valid_a !== 1'b0 || o_row_a !== 13'd4 || o_col_a !== 13'd6 || o_count_a !== 4'd9 || o_color_a !== 1'b1) begin
      failures++;
      $display("FAIL hold_outputs actual=%0d/%0d/%0d/%0d/%0d required=0/4/6/9/1",
               o_valid_a, o_row_a, o_col_a, o_count_a, o_color_a);
    end
  endtask

  task automatic test_isolated();
    clear_q(); fill(1'b0); img[3][3] = 1'b1;
    drive_frame(1'b0, 1'b0, 3);
    check_frame("isolated");
    checks++;
    if (q_cnt.size() < 35 || q_cnt[24] !== 1 || q_c5[24] !== 1'b0 || q_cnt[8] !== 0 || q_cnt[16] !== 1) begin
      failures++;
      $display("FAIL isolated_hand actual_n=%0d required=centre(3,3)=1 centre(2,2)=1 centre(1,1)=0", q_cnt.size());
    end
  endtask

  task automatic test_threshold();
    clear_q(); fill(1'b0);
    img[1][1] = 1'b1; img[1][2] = 1'b1; img[1][3] = 1'b1; img[2][1] = 1'b1; img[2][2] = 1'b1;
    drive_frame(1'b0, 1'b0, 3);
    check_frame("thresh_five");
    checks++;
    if (q_cnt.size() < 35 || q_cnt[16] !== 5 || q_c5[16] !== 1'b1 || q_c9[16] !== 1'b0) begin
      failures++;
      $display("FAIL thresh_five_hand actual_n=%0d required=cnt5 c5=1 c9=0", q_cnt.size());
    end
    clear_q(); img[2][2] = 1'b0;
    drive_frame(1'b0, 1'b0, 3);
    check_frame("thresh_four");
    checks++;
    if (q_cnt.size() < 35 || q_cnt[16] !== 4 || q_c5[16] !== 1'b0) begin
      failures++;
      $display("FAIL thresh_four_hand actual_n=%0d required=cnt4 c5=0", q_cnt.size());
    end
    clear_q(); fill(1'b1); img[3][3] = 1'b0;
    drive_frame(1'b0, 1'b0, 3);
    check_frame("thresh_nine");
    checks++;
    if (q_cnt.size() < 35 || q_c9[8] !== 1'b1 || q_cnt[16] !== 8 || q_c9[16] !== 1'b0 || q_c5[16] !== 1'b1) begin
      failures++;
      $display("FAIL thresh_nine_hand actual_n=%0d required=c9(1,1)=1 cnt(2,2)=8 c9=0", q_cnt.size());
    end
  endtask

  task automatic test_gaps_oor();
    clear_q(); fill(1'b0);
    img[1][1] = 1'b1; img[1][2] = 1'b1; img[1][3] = 1'b1; img[2][1] = 1'b1; img[2][2] = 1'b1;
    img[3][5] = 1'b1; img[4][6] = 1'b1; img[4][4] = 1'b1;
    drive_frame(1'b1, 1'b1, 3);
    check_frame("gaps_oor");
  endtask

  task automatic test_latency();
    clear_q();
    for (int c = 0; c < W; c++) pixel(1'b1, 0, c, 1'b1);
    pixel(1'b1, 1, 0, 1'b1);
    pixel(1'b1, 1, 1, 1'b1);
    pixel(1'b0, 0, 0, 1'b0);
    checks++;
    if (o_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL latency_early actual=%0d required=0", o_valid_a);
    end
    @(negedge clk);
    checks++;
    if (o_valid_a !== 1'b1 || o_row_a !== 13'd0 || o_col_a !== 13'd0 || o_count_a !== 4'd0) begin
      failures++;
      $display("FAIL latency_one actual=%0d/%0d/%0d/%0d required=1/0/0/0", o_valid_a, o_row_a, o_col_a, o_count_a);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    fill(1'b1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || (r == 3 && c < 2)) pixel(1'b1, r, c, 1'b1);
    pixel(1'b0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid_a, o_row_a, o_col_a, o_count_a, o_color_a} !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_async actual=%0d/%0d/%0d/%0d/%0d required=0/0/0/0/0",
               o_valid_a, o_row_a, o_col_a, o_count_a, o_color_a);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_q();
    for (int r = 3; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r > 3 || c >= 2) pixel(1'b1, r, c, 1'b1);
    idle(3);
    checks++;
    if (q_row.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_nosync actual=%0d required=0", q_row.size());
    end
    clear_q();
    drive_frame(1'b0, 1'b0, 3);
    check_frame("reset_mid_next");
  endtask

  task automatic test_back_to_back();
    clear_q(); fill(1'b1);
    drive_frame(1'b0, 1'b0, 0);
    fill(1'b0);
    drive_frame(1'b0, 1'b0, 3);
    checks++;
    if (q_row.size() !== 70) begin
      failures++;
      $display("FAIL b2b_count actual=%0d required=70", q_row.size());
    end
    for (int k = 0; k < 70 && k < q_row.size(); k++) begin
      int er, ec, en;
      er = (k % 35) / 7; ec = k % 7;
      en = (k < 35 && er != 0 && ec != 0) ? 9 : 0;
      checks++;
      if (q_row[k] !== er || q_col[k] !== ec || q_cnt[k] !== en || q_c5[k] !== (en >= 5)) begin
        failures++;
        $display("FAIL b2b out%0d actual=(%0d,%0d) cnt=%0d c5=%0d required=(%0d,%0d) cnt=%0d",
                 k, q_row[k], q_col[k], q_cnt[k], q_c5[k], er, ec, en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_isolated();
    test_threshold();
    test_gaps_oor();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
